// File: rtl/bullet_pkg.sv
// Shared slot layout, direction encoding and sizing constants for the bullet scheduler.
package bullet_pkg;

  localparam int unsigned DEFAULT_MAX_BULLETS = 64;
  localparam int unsigned BULLET_SIZE         = 8;
  localparam int unsigned SLOT_W              = 32;
  localparam int unsigned IDX_W               = 6;
  localparam int unsigned COORD_W             = 9;

  localparam int unsigned SLOT_X_MSB      = 31;
  localparam int unsigned SLOT_X_LSB      = 23;
  localparam int unsigned SLOT_Y_MSB      = 22;
  localparam int unsigned SLOT_Y_LSB      = 14;
  localparam int unsigned SLOT_DIR_MSB    = 13;
  localparam int unsigned SLOT_DIR_LSB    = 12;
  localparam int unsigned SLOT_OWNER_BIT  = 11;
  localparam int unsigned SLOT_ACTIVE_BIT = 5;

  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirRight = 2'd1,
    DirDown  = 2'd2,
    DirLeft  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDone
  } state_e;

  function automatic logic [SLOT_W-1:0] pack_slot(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y,
                                                  input logic [1:0]         dir,
                                                  input logic               owner);
    logic [SLOT_W-1:0] w;
    w                             = '0;
    w[SLOT_X_MSB:SLOT_X_LSB]      = x;
    w[SLOT_Y_MSB:SLOT_Y_LSB]      = y;
    w[SLOT_DIR_MSB:SLOT_DIR_LSB]  = dir;
    w[SLOT_OWNER_BIT]             = owner;
    w[SLOT_ACTIVE_BIT]            = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/bullet_scheduler_if.sv
// Fire/kill handshake, frame strobe and slot-array bus of the bullet scheduler.
interface bullet_scheduler_if
  import bullet_pkg::*;
#(
  parameter int unsigned MAX_BULLETS = DEFAULT_MAX_BULLETS
);
  logic                       screenEnd;
  logic [1:0]                 fire_req;
  logic [COORD_W-1:0]         fire_x0;
  logic [COORD_W-1:0]         fire_x1;
  logic [COORD_W-1:0]         fire_y0;
  logic [COORD_W-1:0]         fire_y1;
  logic [1:0]                 fire_dir0;
  logic [1:0]                 fire_dir1;
  logic [1:0]                 fire_ack;
  logic                       fire_full;
  logic                       kill_valid;
  logic [IDX_W-1:0]           kill_idx;
  logic [SLOT_W*MAX_BULLETS-1:0] allBulletContents;
  logic                       busy;

  modport master (
    output screenEnd, fire_req, fire_x0, fire_x1, fire_y0, fire_y1, fire_dir0, fire_dir1,
           kill_valid, kill_idx,
    input  fire_ack, fire_full, allBulletContents, busy
  );

  modport slave (
    input  screenEnd, fire_req, fire_x0, fire_x1, fire_y0, fire_y1, fire_dir0, fire_dir1,
           kill_valid, kill_idx,
    output fire_ack, fire_full, allBulletContents, busy
  );
endinterface

// File: rtl/bullet_free_finder.sv
// Combinational priority encoder: lowest-index slot whose active bit is clear.
module bullet_free_finder
  import bullet_pkg::*;
#(
  parameter int unsigned MAX_BULLETS = DEFAULT_MAX_BULLETS
) (
  input  logic [MAX_BULLETS-1:0] active_i,
  output logic                   found_o,
  output logic [IDX_W-1:0]       idx_o
);

  // Scan downwards so the last hit is the lowest free index.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = int'(MAX_BULLETS) - 1; i >= 0; i--) begin
      if (!active_i[i]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bullet_scheduler.sv
// Bullet slot store: per-frame movement sweep, round-robin fire spawning and hit kills.
module bullet_scheduler
  import bullet_pkg::*;
#(
  parameter int unsigned MAX_BULLETS  = DEFAULT_MAX_BULLETS,
  parameter int unsigned BULLET_SPEED = 4,
  parameter int unsigned X_MAX        = 503,
  parameter int unsigned Y_MAX        = 471
) (
  input logic              clk,
  input logic              reset,
  bullet_scheduler_if.slave bus
);

  // One extra bit so a move past zero shows up as a negative value.
  typedef logic signed [COORD_W:0] coord_t;
  localparam coord_t Speed  = coord_t'(BULLET_SPEED);
  localparam coord_t XLimit = coord_t'(X_MAX);
  localparam coord_t YLimit = coord_t'(Y_MAX);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              frame_pend_q, frame_pend_d;
  logic              screen_end_q;
  logic              rr_last_q, rr_last_d;
  logic [1:0]        armed_q, armed_d;
  logic [1:0]        ack_q, ack_d;
  logic              full_q, full_d;
  logic [SLOT_W-1:0] slots_q [MAX_BULLETS];
  logic [SLOT_W-1:0] slots_d [MAX_BULLETS];

  logic [MAX_BULLETS-1:0] active_vec;
  logic                   free_found;
  logic [IDX_W-1:0]       free_idx;
  logic                   screen_rise;
  logic [1:0]             eligible;
  logic                   grant;
  logic                   kill_hit;
  logic [SLOT_W-1:0]      sweep_cur, sweep_next;
  coord_t                 nx, ny;

  for (genvar i = 0; i < int'(MAX_BULLETS); i++) begin : g_slot
    assign active_vec[i]                            = slots_q[i][SLOT_ACTIVE_BIT];
    assign bus.allBulletContents[i*SLOT_W +: SLOT_W] = slots_q[i];
  end

  bullet_free_finder #(
    .MAX_BULLETS (MAX_BULLETS)
  ) u_free_finder (
    .active_i (active_vec),
    .found_o  (free_found),
    .idx_o    (free_idx)
  );

  assign screen_rise = bus.screenEnd & ~screen_end_q;
  // A player is eligible only after it has dropped its request since the last ack.
  assign eligible    = bus.fire_req & armed_q;
  assign grant       = (&eligible) ? ~rr_last_q : eligible[1];
  assign kill_hit    = bus.kill_valid && (32'(bus.kill_idx) < MAX_BULLETS);

  always_comb begin
    sweep_cur  = slots_q[idx_q];
    nx         = coord_t'({1'b0, sweep_cur[SLOT_X_MSB:SLOT_X_LSB]});
    ny         = coord_t'({1'b0, sweep_cur[SLOT_Y_MSB:SLOT_Y_LSB]});
    sweep_next = sweep_cur;
    case (dir_e'(sweep_cur[SLOT_DIR_MSB:SLOT_DIR_LSB]))
      DirUp:    ny = ny - Speed;
      DirRight: nx = nx + Speed;
      DirDown:  ny = ny + Speed;
      DirLeft:  nx = nx - Speed;
    endcase
    if (sweep_cur[SLOT_ACTIVE_BIT]) begin
      if (nx < 0 || nx > XLimit || ny < 0 || ny > YLimit) begin
        sweep_next = '0;
      end else begin
        sweep_next[SLOT_X_MSB:SLOT_X_LSB] = nx[COORD_W-1:0];
        sweep_next[SLOT_Y_MSB:SLOT_Y_LSB] = ny[COORD_W-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    frame_pend_d = frame_pend_q | screen_rise;
    rr_last_d    = rr_last_q;
    ack_d        = '0;
    full_d       = 1'b0;
    slots_d      = slots_q;
    unique case (state_q)
      StIdle: begin
        if (frame_pend_q) begin
          state_d      = StSweep;
          idx_d        = '0;
          frame_pend_d = screen_rise;
        end else if (|eligible) begin
          ack_d[grant] = 1'b1;
          full_d       = ~free_found;
          rr_last_d    = grant;
          if (free_found) begin
            slots_d[free_idx] = grant ? pack_slot(bus.fire_x1, bus.fire_y1, bus.fire_dir1, 1'b1)
                                      : pack_slot(bus.fire_x0, bus.fire_y0, bus.fire_dir0, 1'b0);
          end
        end
      end
      StSweep: begin
        slots_d[idx_q] = sweep_next;
        if (idx_q == IDX_W'(MAX_BULLETS - 1)) begin
          state_d = StDone;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Kill is applied last so it overrides any sweep or spawn write to the same slot.
    if (kill_hit) begin
      slots_d[bus.kill_idx] = '0;
    end
    armed_d = (armed_q | ~bus.fire_req) & ~ack_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      frame_pend_q <= 1'b0;
      screen_end_q <= 1'b0;
      rr_last_q    <= 1'b1;
      armed_q      <= 2'b11;
      ack_q        <= '0;
      full_q       <= 1'b0;
      for (int i = 0; i < int'(MAX_BULLETS); i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_pend_q <= frame_pend_d;
      screen_end_q <= bus.screenEnd;
      rr_last_q    <= rr_last_d;
      armed_q      <= armed_d;
      ack_q        <= ack_d;
      full_q       <= full_d;
      slots_q      <= slots_d;
    end
  end

  assign bus.fire_ack  = ack_q;
  assign bus.fire_full = full_q;
  assign bus.busy      = (state_q == StSweep) || (state_q == StDone);

endmodule
